serial_sum_collector: RTL

//  Bit-serial adder and deserializer. Sits downstream of the single-bit sum/carry

---
 rtl/serial_sum_collector_if.sv | 26 ++
 rtl/serial_sum_collector.sv | 92 +++++++++
 2 files changed

// File: rtl/serial_sum_collector_if.sv
// Bit-pair input and word output handshakes of the serial sum collector.
// The slave modport is the collector's view; master is the driver/consumer side.
interface serial_sum_collector_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_a;
  logic             in_b;
  logic             in_cin;
  logic             in_flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_flush, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_flush, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/serial_sum_collector.sv
// Bit-serial adder: adds LSB-first operand bit pairs with a running carry and
// presents each completed WIDTH-bit sum plus carry-out on a valid/ready port.
module serial_sum_collector #(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  serial_sum_collector_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic flush, beat, lastBeat, carryIn, sumBit, carryOut;

  always_comb begin
    flush    = (state_q == COLLECT) && bus.in_flush;
    beat     = bus.in_valid && bus.in_ready && !flush;
    lastBeat = beat && (count_q == LastCount);
    carryIn  = (count_q == '0) ? bus.in_cin : carry_q;
    sumBit   = bus.in_a ^ bus.in_b ^ carryIn;
    carryOut = (bus.in_a & bus.in_b) | (bus.in_a & carryIn) | (bus.in_b & carryIn);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (lastBeat)      state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = COLLECT;
      default:                    state_d = COLLECT;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == COLLECT) && !rst;
    bus.out_valid = (state_q == HOLD);
    bus.out_sum   = sum_q;
    bus.out_cout  = cout_q;
  end

  // Flush beats a coincident accepted bit; sum bits enter at the MSB so the
  // first bit received ends up in bit 0 once the word is complete.
  always_comb begin
    count_d = count_q;
    carry_d = carry_q;
    shift_d = shift_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (flush) begin
      count_d = '0;
      carry_d = 1'b0;
      shift_d = '0;
    end else if (beat) begin
      carry_d = carryOut;
      shift_d = {sumBit, shift_q[WIDTH-1:1]};
      count_d = lastBeat ? '0 : count_q + CW'(1);
      if (lastBeat) begin
        sum_d  = shift_d;
        cout_d = carryOut;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      carry_q <= 1'b0;
      shift_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      shift_q <= shift_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
endmodule
